seq_pattern_detect: RTL and testbench

//  Parametrised serial pattern detector, successor to the fixed 6-bit framed detector.
//  - Pattern width is set by parameter; the pattern itself is loadable at run time.
//  - Two modes, selectable at run time: framed (non-overlapping) or sliding (overlapping).
//  - Input has a data_valid qualifier.
//  - Sits on the serial input path; match/not_match pulses feed the frame-sync and error-count logic.

---
 rtl/seq_det_pkg.sv | 21 ++
 rtl/seq_det_cfg.sv | 55 +++++
 rtl/seq_pattern_detect.sv | 138 +++++++++++++
 tb/tb_seq_pattern_detect.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and helpers for the serial pattern detector.
//   seq_state_e   detector FSM states (framed: ST_CMP/ST_ERR, sliding: ST_FILL/ST_WIN)
//   MODE_FRAMED / MODE_SLIDING   values of the run-time mode bit
//   idx_width()   width of a counter that must hold 0..n inclusive
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_CMP  = 2'd0,
    ST_ERR  = 2'd1,
    ST_FILL = 2'd2,
    ST_WIN  = 2'd3
  } seq_state_e;

  localparam logic MODE_FRAMED  = 1'b0;
  localparam logic MODE_SLIDING = 1'b1;

  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_det_cfg.sv
// seq_det_cfg: run-time configuration registers of the pattern detector.
// Optional macro SEQ_DET_MASK_EN adds a don't-care mask register.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   cfg_load        1-cycle load strobe
//   cfg_pattern     pattern to load (MSB first on the line)
//   cfg_mode        mode to load (0 framed, 1 sliding)
//   cfg_mask        mask to load (only with SEQ_DET_MASK_EN)
//   pat_r, mode_r   active pattern and mode
//   mask_r          active mask (only with SEQ_DET_MASK_EN)
//   restart         detection restart strobe, same cycle as cfg_load
//   restart_mode    mode that takes effect with the restart
module seq_det_cfg
  import seq_det_pkg::*;
#(
  parameter int                 SEQ_LEN = 6,
  parameter logic [SEQ_LEN-1:0] PATTERN = 6'b011100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [SEQ_LEN-1:0] cfg_pattern,
  input  logic               cfg_mode,
`ifdef SEQ_DET_MASK_EN
  input  logic [SEQ_LEN-1:0] cfg_mask,
  output logic [SEQ_LEN-1:0] mask_r,
`endif
  output logic [SEQ_LEN-1:0] pat_r,
  output logic               mode_r,
  output logic               restart,
  output logic               restart_mode
);

  // The restart is combinational so the FSM reloads on the same edge as the
  // registers; the FSM picks its start state from the incoming mode.
  assign restart      = cfg_load;
  assign restart_mode = cfg_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_r  <= PATTERN;
      mode_r <= MODE_FRAMED;
`ifdef SEQ_DET_MASK_EN
      mask_r <= '1;
`endif
    end else if (cfg_load) begin
      pat_r  <= cfg_pattern;
      mode_r <= cfg_mode;
`ifdef SEQ_DET_MASK_EN
      mask_r <= cfg_mask;
`endif
    end
  end

endmodule

// File: rtl/seq_pattern_detect.sv
// seq_pattern_detect: parametrised serial pattern detector with framed
// (non-overlapping) and sliding (overlapping) modes.
// Optional macro SEQ_DET_MASK_EN adds cfg_mask (don't-care bits).
// Ports:
//   clk, rst_n     clock, async active-low reset
//   data_valid     data carries a valid serial bit
//   data           serial bit
//   cfg_load       load cfg_pattern/cfg_mode(/cfg_mask) and restart detection
//   cfg_pattern    new pattern, MSB received first
//   cfg_mode       0 framed, 1 sliding
//   cfg_mask       don't-care mask, 0 = ignore bit (only with SEQ_DET_MASK_EN)
//   match          1-cycle pulse: window equals pattern
//   not_match      1-cycle pulse: complete window differs
//   bit_idx        valid bits in current frame/fill, 0..SEQ_LEN
//
// state   | meaning
// ST_CMP  | framed: every bit of this frame so far matched
// ST_ERR  | framed: mismatch seen, waiting for the frame to end
// ST_FILL | sliding: window not yet full, no pulses
// ST_WIN  | sliding: window full, one pulse per valid bit
module seq_pattern_detect
  import seq_det_pkg::*;
#(
  parameter int                 SEQ_LEN = 6,
  parameter logic [SEQ_LEN-1:0] PATTERN = 6'b011100
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              data_valid,
  input  logic                              data,
  input  logic                              cfg_load,
  input  logic [SEQ_LEN-1:0]                cfg_pattern,
  input  logic                              cfg_mode,
`ifdef SEQ_DET_MASK_EN
  input  logic [SEQ_LEN-1:0]                cfg_mask,
`endif
  output logic                              match,
  output logic                              not_match,
  output logic [idx_width(SEQ_LEN)-1:0]     bit_idx
);

  localparam int IW = idx_width(SEQ_LEN);

  logic [SEQ_LEN-1:0] pat_r;
  logic [SEQ_LEN-1:0] mask_w;
  logic               mode_r;
  logic               restart;
  logic               restart_mode;

  seq_det_cfg #(
    .SEQ_LEN (SEQ_LEN),
    .PATTERN (PATTERN)
  ) u_cfg (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_load     (cfg_load),
    .cfg_pattern  (cfg_pattern),
    .cfg_mode     (cfg_mode),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask     (cfg_mask),
    .mask_r       (mask_w),
`endif
    .pat_r        (pat_r),
    .mode_r       (mode_r),
    .restart      (restart),
    .restart_mode (restart_mode)
  );

`ifndef SEQ_DET_MASK_EN
  assign mask_w = '1;
`endif

  seq_state_e         state_r;
  logic [IW-1:0]      bit_idx_r;
  logic [SEQ_LEN-1:0] win_r;

  logic [SEQ_LEN-1:0] pat_sh;
  logic [SEQ_LEN-1:0] msk_sh;
  logic [SEQ_LEN-1:0] win_next;
  logic               bit_ok;
  logic               win_ok;
  logic               last_bit;

  // Shifting left by bit_idx brings the pattern bit expected next to the
  // MSB, avoiding a variable index of mixed width.
  always_comb begin
    pat_sh   = pat_r  << bit_idx_r;
    msk_sh   = mask_w << bit_idx_r;
    bit_ok   = !msk_sh[SEQ_LEN-1] || (data == pat_sh[SEQ_LEN-1]);
    win_next = {win_r[SEQ_LEN-2:0], data};
    win_ok   = ((win_next ^ pat_r) & mask_w) == '0;
    last_bit = (bit_idx_r == IW'(SEQ_LEN - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_CMP;
      bit_idx_r <= '0;
      win_r     <= '0;
      match     <= 1'b0;
      not_match <= 1'b0;
    end else begin
      match     <= 1'b0;
      not_match <= 1'b0;
      if (restart) begin
        bit_idx_r <= '0;
        win_r     <= '0;
        state_r   <= (restart_mode == MODE_SLIDING) ? ST_FILL : ST_CMP;
      end else if (data_valid) begin
        if (mode_r == MODE_SLIDING) begin
          win_r <= win_next;
          // The bit that fills the window is also the first one judged.
          if (state_r == ST_WIN || last_bit) begin
            match     <= win_ok;
            not_match <= !win_ok;
            bit_idx_r <= IW'(SEQ_LEN);
            state_r   <= ST_WIN;
          end else begin
            bit_idx_r <= bit_idx_r + IW'(1);
          end
        end else begin
          if (last_bit) begin
            bit_idx_r <= '0;
            state_r   <= ST_CMP;
            if (state_r == ST_CMP && bit_ok) match <= 1'b1;
            else                             not_match <= 1'b1;
          end else begin
            bit_idx_r <= bit_idx_r + IW'(1);
            if (!bit_ok) state_r <= ST_ERR;
          end
        end
      end
    end
  end

  assign bit_idx = bit_idx_r;

endmodule

// File: tb/tb_seq_pattern_detect.sv
// Bench for seq_pattern_detect: a SEQ_LEN=6 default instance and a SEQ_LEN=4
// instance (reset pattern 1011). Vectors are queued as records and applied
// one clock each; outputs are sampled 1 time unit after the rising edge.
module tb_seq_pattern_detect;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       dv6 = 0, d6 = 0, ld6 = 0, mode6 = 0;
  logic [5:0] pat6 = '0, mask6 = '1;
  logic       m6, nm6;
  logic [2:0] idx6;

  logic       dv4 = 0, d4 = 0, ld4 = 0, mode4 = 0;
  logic [3:0] pat4 = '0, mask4 = '1;
  logic       m4, nm4;
  logic [2:0] idx4;

  seq_pattern_detect #(.SEQ_LEN(6), .PATTERN(6'b011100)) dut6 (
    .clk(clk), .rst_n(rst_n), .data_valid(dv6), .data(d6), .cfg_load(ld6),
    .cfg_pattern(pat6), .cfg_mode(mode6),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask(mask6),
`endif
    .match(m6), .not_match(nm6), .bit_idx(idx6)
  );

  seq_pattern_detect #(.SEQ_LEN(4), .PATTERN(4'b1011)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_valid(dv4), .data(d4), .cfg_load(ld4),
    .cfg_pattern(pat4), .cfg_mode(mode4),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask(mask4),
`endif
    .match(m4), .not_match(nm4), .bit_idx(idx4)
  );

  typedef struct {
    logic       sel;   // 0 = dut6, 1 = dut4
    logic       v;
    logic       d;
    logic       ld;
    logic [5:0] pat;
    logic [5:0] mask;
    logic       mode;
    logic       m;
    logic       nm;
    int         idx;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vnum  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic sel, input logic v, input logic d, input logic ld,
                     input logic [5:0] pat, input logic [5:0] mask, input logic mode,
                     input logic m, input logic nm, input int idx);
    vec_t t;
    t.sel = sel; t.v = v; t.d = d; t.ld = ld; t.pat = pat; t.mask = mask;
    t.mode = mode; t.m = m; t.nm = nm; t.idx = idx;
    vq.push_back(t);
  endtask

  task automatic bit6(input logic d, input logic m, input logic nm, input int idx);
    add(0, 1, d, 0, '0, '1, 0, m, nm, idx);
  endtask

  task automatic bit4(input logic d, input logic m, input logic nm, input int idx);
    add(1, 1, d, 0, '0, '1, 0, m, nm, idx);
  endtask

  task automatic idle_all();
    dv6 = 0; ld6 = 0; dv4 = 0; ld4 = 0;
  endtask

  task automatic run_queue();
    foreach (vq[i]) begin
      idle_all();
      if (vq[i].sel == 1'b0) begin
        dv6 = vq[i].v; d6 = vq[i].d; ld6 = vq[i].ld;
        pat6 = vq[i].pat; mask6 = vq[i].mask; mode6 = vq[i].mode;
      end else begin
        dv4 = vq[i].v; d4 = vq[i].d; ld4 = vq[i].ld;
        pat4 = vq[i].pat[3:0]; mask4 = vq[i].mask[3:0]; mode4 = vq[i].mode;
      end
      @(posedge clk);
      #1;
      if (vq[i].sel == 1'b0) begin
        chk($sformatf("v%0d dut6 match", vnum), int'(m6), int'(vq[i].m));
        chk($sformatf("v%0d dut6 not_match", vnum), int'(nm6), int'(vq[i].nm));
        chk($sformatf("v%0d dut6 bit_idx", vnum), int'(idx6), vq[i].idx);
      end else begin
        chk($sformatf("v%0d dut4 match", vnum), int'(m4), int'(vq[i].m));
        chk($sformatf("v%0d dut4 not_match", vnum), int'(nm4), int'(vq[i].nm));
        chk($sformatf("v%0d dut4 bit_idx", vnum), int'(idx4), vq[i].idx);
      end
      vnum++;
    end
    idle_all();
    vq.delete();
  endtask

  initial begin
    logic [17:0] s18;
    logic [5:0]  f;
    logic [6:0]  s7;

    // Reset state
    #2;
    chk("reset dut6 match", int'(m6), 0);
    chk("reset dut6 not_match", int'(nm6), 0);
    chk("reset dut6 bit_idx", int'(idx6), 0);
    chk("reset dut4 match", int'(m4), 0);
    chk("reset dut4 bit_idx", int'(idx4), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Framed, default pattern: 011100 011101 011100 -> match, not_match, match
    s18 = 18'b011100_011101_011100;
    for (int i = 0; i < 18; i++) begin
      if (i % 6 == 5) bit6(s18[17-i], (i != 11), (i == 11), 0);
      else            bit6(s18[17-i], 0, 0, (i % 6) + 1);
    end
    // First bit wrong, rest right: the frame still ends in not_match
    f = 6'b111100;
    for (int i = 0; i < 6; i++) bit6(f[5-i], 0, (i == 5), (i + 1) % 6);
    // data_valid gaps: idle cycles hold bit_idx and give no pulse
    f = 6'b011100;
    for (int i = 0; i < 6; i++) begin
      bit6(f[5-i], (i == 5), 0, (i + 1) % 6);
      add(0, 0, 1, 0, '0, '1, 0, 0, 0, (i + 1) % 6);
    end
    // Mid-frame cfg_load together with a valid bit: bit dropped, frame abandoned
    bit6(0, 0, 0, 1); bit6(1, 0, 0, 2); bit6(1, 0, 0, 3);
    add(0, 1, 1, 1, 6'b011100, '1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) bit6(f[5-i], (i == 5), 0, (i + 1) % 6);
    // Abandon after 5 bits while switching to pattern 101010
    for (int i = 0; i < 5; i++) bit6(f[5-i], 0, 0, i + 1);
    add(0, 0, 0, 1, 6'b101010, '1, 0, 0, 0, 0);
    f = 6'b101010;
    for (int i = 0; i < 6; i++) bit6(f[5-i], (i == 5), 0, (i + 1) % 6);
    f = 6'b011100;
    for (int i = 0; i < 6; i++) bit6(f[5-i], 0, (i == 5), (i + 1) % 6);

    // dut4 framed with reset pattern 1011
    bit4(1, 0, 0, 1); bit4(0, 0, 0, 2); bit4(1, 0, 0, 3); bit4(1, 1, 0, 0);
    bit4(1, 0, 0, 1); bit4(1, 0, 0, 2); bit4(1, 0, 0, 3); bit4(1, 0, 1, 0);
    // dut4 sliding 1011, stream 1011011 -> matches after bits 4 and 7
    add(1, 0, 0, 1, 6'b001011, '1, 1, 0, 0, 0);
    s7 = 7'b1011011;
    bit4(s7[6], 0, 0, 1); bit4(s7[5], 0, 0, 2); bit4(s7[4], 0, 0, 3);
    bit4(s7[3], 1, 0, 4); bit4(s7[2], 0, 1, 4); bit4(s7[1], 0, 1, 4);
    bit4(s7[0], 1, 0, 4);
    add(1, 0, 0, 0, '0, '1, 0, 0, 0, 4);
    bit4(0, 0, 1, 4);                       // window 0110
    // Restart while sliding: fill again from empty, no pulses
    add(1, 1, 1, 1, 6'b001011, '1, 1, 0, 0, 0);
    bit4(1, 0, 0, 1); bit4(0, 0, 0, 2); bit4(1, 0, 0, 3); bit4(1, 1, 0, 4);
    run_queue();

    // Async reset while a match pulse is high
    add(0, 0, 0, 1, 6'b110011, '1, 1, 0, 0, 0);
    f = 6'b110011;
    for (int i = 0; i < 6; i++) bit6(f[5-i], (i == 5), 0, i + 1);
    run_queue();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset match", int'(m6), 0);
    chk("async reset not_match", int'(nm6), 0);
    chk("async reset bit_idx", int'(idx6), 0);
    @(negedge clk);
    rst_n = 1'b1;
    f = 6'b011100;
    for (int i = 0; i < 6; i++) bit6(f[5-i], (i == 5), 0, (i + 1) % 6);
    run_queue();

`ifdef SEQ_DET_MASK_EN
    // Two LSBs don't-care
    add(0, 0, 0, 1, 6'b011100, 6'b111100, 0, 0, 0, 0);
    f = 6'b011111;
    for (int i = 0; i < 6; i++) bit6(f[5-i], (i == 5), 0, (i + 1) % 6);
    f = 6'b111100;
    for (int i = 0; i < 6; i++) bit6(f[5-i], 0, (i == 5), (i + 1) % 6);
    // All-zero mask: every complete window matches
    add(0, 0, 0, 1, 6'b011100, 6'b000000, 0, 0, 0, 0);
    f = 6'b101010;
    for (int i = 0; i < 6; i++) bit6(f[5-i], (i == 5), 0, (i + 1) % 6);
    run_queue();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
